// File: rtl/button_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, 4-state debounce FSM,
// registered level/press/release/long-press pulses and a toggle for an LED.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_WIDTH       = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic but,
  output logic level,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic toggle
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_MAX =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_MAX =
    CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  state_t state, state_n;

  logic                 sync1;
  logic                 but_s;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic [CNT_WIDTH-1:0] hold;
  logic                 long_fired;
  logic                 held;
  logic                 rise;
  logic                 fall;
  logic                 fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      but_s <= 1'b0;
    end else begin
      sync1 <= but;
      but_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Wait states count stable samples; the counter never passes DEB_MAX.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      RELEASED: begin
        if (but_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!but_s)
          state_n = RELEASED;
        else if (cnt == DEB_MAX)
          state_n = PRESSED;
        else
          cnt_n = cnt + ONE;
      end
      PRESSED: begin
        if (!but_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (but_s)
          state_n = PRESSED;
        else if (cnt == DEB_MAX)
          state_n = RELEASED;
        else
          cnt_n = cnt + ONE;
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
  end

  assign held = (state == PRESSED) || (state == RELEASE_WAIT);
  assign rise = held & ~level;
  assign fall = ~held & level;
  assign fire = (state == PRESSED) && level &&
                (hold == LONG_MAX) && !long_fired;

  // Outputs trail the FSM by one edge; level remembers the last
  // accepted state so entry/exit are seen as its edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      level      <= 1'b0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      toggle     <= 1'b0;
      long_fired <= 1'b0;
      hold       <= '0;
    end else begin
      level      <= held;
      press      <= rise;
      release_p  <= fall;
      long_press <= fire;
      if (rise)
        toggle <= ~toggle;
      if (rise) begin
        hold       <= '0;
        long_fired <= 1'b0;
      end else begin
        if (state == PRESSED && hold != LONG_MAX)
          hold <= hold + ONE;
        if (fire)
          long_fired <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce against a
// run-length reference model of the debounce rules.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk;
  logic rst;
  logic but;
  logic level;
  logic press;
  logic release_p;
  logic long_press;
  logic toggle;

  int checks   = 0;
  int failures = 0;

  int n_press = 0;
  int n_rel   = 0;
  int n_long  = 0;

  bit m_h0, m_h1;
  bit acc;
  int run;
  bit m_lvl, m_press, m_rel, m_long, m_tog, m_fired;
  int hold;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG),
    .CNT_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .but(but),
    .level(level),
    .press(press),
    .release_p(release_p),
    .long_press(long_press),
    .toggle(toggle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // A change is accepted after DEB+1 consecutive synchronized samples
  // that differ from the accepted state; outputs follow one edge later.
  task automatic model_edge(input logic b, input logic r);
    bit bs, pst;
    if (r) begin
      m_h0 = 0; m_h1 = 0; acc = 0; run = 0;
      m_lvl = 0; m_press = 0; m_rel = 0; m_long = 0;
      m_tog = 0; m_fired = 0; hold = 0;
    end else begin
      bs   = m_h1;
      m_h1 = m_h0;
      m_h0 = b;
      pst  = acc && (run == 0);
      m_press = acc && !m_lvl;
      m_rel   = !acc && m_lvl;
      m_long  = pst && m_lvl && (hold == LONG - 1) && !m_fired;
      if (m_press) begin
        hold    = 0;
        m_fired = 0;
      end else if (pst && hold < LONG - 1) begin
        hold++;
      end
      if (m_long) m_fired = 1;
      m_tog = m_tog ^ m_press;
      m_lvl = acc;
      if (bs != acc) begin
        run++;
        if (run == DEB + 1) begin
          acc = !acc;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    but = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    chk("level", level, m_lvl);
    chk("press", press, m_press);
    chk("release", release_p, m_rel);
    chk("long_press", long_press, m_long);
    chk("toggle", toggle, m_tog);
    n_press += press;
    n_rel   += release_p;
    n_long  += long_press;
  endtask

  task automatic do_reset(input logic b);
    for (int i = 0; i < 2; i++) begin
      step(b, 1'b1);
      chk("rst_out",
          {level, press, release_p, long_press, toggle}, 0);
    end
    n_press = 0;
    n_rel   = 0;
    n_long  = 0;
  endtask

  task automatic hold_but(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int  seg;
    bit  cur;
    logic b;
    but = 1'b0;
    rst = 1'b1;

    // reset with button held, then fresh debounce
    do_reset(1'b1);
    for (int e = 0; e < 10; e++) begin
      step(1'b1, 1'b0);
      chk("rst_press", press, e == 7);
    end
    hold_but(1'b0, 12);

    // clean press and release
    do_reset(1'b0);
    hold_but(1'b0, 3);
    for (int e = 0; e < 25; e++) begin
      step(e < 12, 1'b0);
      chk("clean_press", press, e == 7);
      chk("clean_rel", release_p, e == 19);
      chk("clean_lvl", level, (e >= 7) && (e < 19));
    end
    chk("clean_tog", toggle, 1);

    // bouncing input never accepted
    do_reset(1'b0);
    hold_but(1'b0, 3);
    repeat (5) begin
      hold_but(1'b1, 3);
      hold_but(1'b0, 1);
    end
    hold_but(1'b0, 10);
    chk("bounce_npress", n_press, 0);
    chk("bounce_tog", toggle, 0);

    // short release glitch while pressed
    do_reset(1'b0);
    hold_but(1'b0, 3);
    hold_but(1'b1, 10);
    hold_but(1'b0, 2);
    hold_but(1'b1, 10);
    chk("rbounce_nrel", n_rel, 0);
    chk("rbounce_lvl", level, 1);
    hold_but(1'b0, 15);
    chk("rbounce_npress", n_press, 1);
    chk("rbounce_nrel2", n_rel, 1);
    chk("rbounce_tog", toggle, 1);

    // long press
    do_reset(1'b0);
    hold_but(1'b0, 3);
    for (int e = 0; e < 40; e++) begin
      step(1'b1, 1'b0);
      chk("long_pulse", long_press, e == 27);
    end
    hold_but(1'b0, 20);
    chk("long_count", n_long, 1);

    // toggle over two presses
    do_reset(1'b0);
    hold_but(1'b0, 3);
    hold_but(1'b1, 12);
    hold_but(1'b0, 15);
    chk("tog_first", toggle, 1);
    hold_but(1'b1, 12);
    hold_but(1'b0, 15);
    chk("tog_second", toggle, 0);
    chk("tog_npress", n_press, 2);
    chk("tog_nrel", n_rel, 2);

    // random segments with bounce and occasional reset
    seg = 0;
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        cur = 1'($urandom % 2);
        seg = $urandom_range(1, 30);
      end
      b = ($urandom % 8 == 0) ? ~cur : cur;
      seg--;
      step(b, ($urandom % 400) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, SHALL set the number of consecutive stable synchronized samples required to accept an edge (1 ms at 100 MHz); legal values >= 1.
REQ-002 Parameter LONG_CYCLES, default 50000000, SHALL set the number of cycles in PRESSED before long_press fires; legal values >= 1.
REQ-003 Parameter CNT_WIDTH, default 26, SHALL set the counter width; it SHALL hold max(DEBOUNCE_CYCLES, LONG_CYCLES) - 1.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 but  input  1  raw pushbutton, asynchronous to clk, active-high, may bounce.
REQ-007 level  output  1  debounced button state, 1 = pressed.
REQ-008 press  output  1  one-cycle pulse on each accepted press.
REQ-009 release  output  1  one-cycle pulse on each accepted release.
REQ-010 long_press  output  1  one-cycle pulse, at most once per accepted press.
REQ-011 toggle  output  1  flips on each accepted press; drives an LED directly.

Function
REQ-012 but SHALL pass through a 2-flop synchronizer; only the second-flop output (but_s) SHALL feed the FSM.
REQ-013 The FSM SHALL have four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 In RELEASED with but_s=1, the FSM SHALL go to PRESS_WAIT with the debounce counter cleared to 0.
REQ-015 In PRESS_WAIT with but_s=0, the FSM SHALL return to RELEASED with no output change (bounce rejected).
REQ-016 In PRESS_WAIT with but_s=1, it SHALL go to PRESSED when the counter = DEBOUNCE_CYCLES-1; otherwise it SHALL increment the counter.
REQ-017 On entry to PRESSED, the block SHALL set level=1, pulse press for exactly one cycle, invert toggle, and clear the hold counter to 0.
REQ-018 Latency: if but is first sampled high at edge 0 and held, level and press SHALL be high after edge DEBOUNCE_CYCLES+3.
REQ-019 In PRESSED, the hold counter SHALL increment each cycle and saturate at LONG_CYCLES-1.
REQ-020 long_press SHALL pulse once on the edge where the hold counter reaches LONG_CYCLES-1; a long_fired flag SHALL suppress repeats until the next accepted press.
REQ-021 In PRESSED with but_s=0, the FSM SHALL go to RELEASE_WAIT with the debounce counter cleared; the hold counter SHALL freeze.
REQ-022 In RELEASE_WAIT with but_s=1, the FSM SHALL return to PRESSED with no press pulse, no toggle change, and the hold counter resuming.
REQ-023 In RELEASE_WAIT with but_s=0 and counter = DEBOUNCE_CYCLES-1, the FSM SHALL go to RELEASED, set level=0 and pulse release for one cycle; otherwise the counter SHALL increment.
REQ-024 press and release SHALL never be high in the same cycle, and each SHALL be separated by at least DEBOUNCE_CYCLES cycles.
REQ-025 If DEBOUNCE_CYCLES=1, an edge SHALL be accepted after one stable sample, with no counter wrap.
REQ-026 No counter SHALL wrap; all counters SHALL saturate or be cleared as stated.

Reset
REQ-027 While rst=1 at a clock edge: state SHALL be RELEASED; level, press, release, long_press, toggle and long_fired SHALL be 0; counters and synchronizer flops SHALL be 0.
REQ-028 Reset mid-operation (any state) SHALL take effect at the next edge, with no pulse emitted on that edge.
REQ-029 After rst deasserts with but held high, a fresh debounce SHALL occur, giving a new press pulse DEBOUNCE_CYCLES+3 edges later.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-030 Reset: rst=1 for 2 cycles with but=1 -> all outputs 0 during reset; press at the 7th edge after rst release.
REQ-031 Clean press: but 0->1 sampled at edge 0, held 12 cycles, then 0 -> level=1 and a press pulse after edge 7; release pulse and level=0 after edge 19; toggle=1.
REQ-032 Bounce: but high for 3 cycles, low, repeated 5 times -> press, level and toggle stay 0 throughout.
REQ-033 Release bounce: while PRESSED, but low 2 cycles then high -> no release pulse, no second press pulse, toggle unchanged.
REQ-034 Long press: but held 40 cycles -> press after edge 7; exactly one long_press pulse after edge 27; none after.
REQ-035 Toggle: two clean presses separated by 15 low cycles -> toggle reads 1 after the first press, 0 after the second; exactly 2 press and 2 release pulses.
